// File: rtl/fp32_result_serializer.sv
// fp32_result_serializer: captures each new FP32 MAC result and streams it byte-wise into the UART TX.
// Define FP32_SER_FRAMING_EN to wrap the four data bytes in a 0xA5 sync byte and an XOR checksum byte.
module fp32_result_serializer #(
  parameter int MSB_FIRST   = 1,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CLKS    = 0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        MAC_VALID_I,
  input  logic [31:0] DELTA_I,
  input  logic        TX_READY_I,
  output logic [7:0]  TX_DATA_O,
  output logic        TX_VALID_O,
  output logic        MAC_READY_O,
  output logic        BUSY_O,
  output logic        DONE_O,
  output logic        RETRY_O
);
`ifdef FP32_SER_FRAMING_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT > 0 ? ACK_TIMEOUT - 1 : 0);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS > 0 ? GAP_CLKS - 1 : 0);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP, NEXT} state_t;
  state_t      state;
  logic        mac_prev;
  logic        mac_edge;
  logic [31:0] shift_word;
  logic [2:0]  idx;
  logic [15:0] ack_cnt;
  logic [15:0] gap_cnt;
  logic [1:0]  data_sel;
  logic [4:0]  data_shift;
  logic [7:0]  data_byte;
  logic [7:0]  cur_byte;
  logic        last_byte;
  assign mac_edge = MAC_VALID_I & ~mac_prev;
  assign last_byte = idx == LAST_IDX;
`ifdef FP32_SER_FRAMING_EN
  logic [7:0] csum;
  // index 0 is the sync byte, so data bytes sit at indices 1..4
  assign data_sel = idx[1:0] - 2'd1;
  assign cur_byte = idx == 3'd0 ? 8'hA5 : last_byte ? csum : data_byte;
`else
  assign data_sel = idx[1:0];
  assign cur_byte = data_byte;
`endif
  assign data_shift = MSB_FIRST != 0 ? {~data_sel, 3'b000} : {data_sel, 3'b000};
  assign data_byte = shift_word[data_shift +: 8];
  assign MAC_READY_O = state == IDLE;
  assign BUSY_O = ~MAC_READY_O;
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= IDLE;
      mac_prev   <= 1'b1;
      shift_word <= '0;
      idx        <= '0;
      ack_cnt    <= '0;
      gap_cnt    <= '0;
      TX_DATA_O  <= '0;
      TX_VALID_O <= 1'b0;
      DONE_O     <= 1'b0;
      RETRY_O    <= 1'b0;
`ifdef FP32_SER_FRAMING_EN
      csum       <= '0;
`endif
    end else begin
      mac_prev   <= MAC_VALID_I;
      TX_VALID_O <= 1'b0;
      DONE_O     <= 1'b0;
      RETRY_O    <= 1'b0;
      case (state)
        IDLE: if (mac_edge) begin
          shift_word <= DELTA_I;
          idx        <= '0;
`ifdef FP32_SER_FRAMING_EN
          csum       <= '0;
`endif
          state      <= SEND;
        end
        SEND: if (TX_READY_I) begin
          TX_VALID_O <= 1'b1;
          TX_DATA_O  <= cur_byte;
          ack_cnt    <= '0;
          state      <= WAIT_ACK;
        end
        // an ack arriving on the timeout cycle takes priority over the retry
        WAIT_ACK: if (!TX_READY_I) begin
          state <= WAIT_DONE;
`ifdef FP32_SER_FRAMING_EN
          if (idx != 3'd0 && !last_byte) csum <= csum ^ data_byte;
`endif
        end else if (ack_cnt == ACK_LAST) begin
          RETRY_O <= 1'b1;
          state   <= SEND;
        end else begin
          ack_cnt <= ack_cnt + 16'd1;
        end
        // DONE_O is raised on entry to NEXT so it pulses while still busy
        WAIT_DONE: if (TX_READY_I) begin
          gap_cnt <= '0;
          DONE_O  <= GAP_CLKS == 0 && last_byte;
          state   <= GAP_CLKS > 0 ? GAP : NEXT;
        end
        GAP: if (gap_cnt == GAP_LAST) begin
          DONE_O <= last_byte;
          state  <= NEXT;
        end else begin
          gap_cnt <= gap_cnt + 16'd1;
        end
        NEXT: if (last_byte) begin
          state <= IDLE;
        end else begin
          idx   <= idx + 3'd1;
          state <= SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_result_serializer.sv
// tb_fp32_result_serializer: scoreboard bench driving MAC results and modelling the UART TX handshake.
module tb_fp32_result_serializer;
  localparam int MSB = 1;
  localparam int TMO = 16;
  localparam int GAP = 4;
`ifdef FP32_SER_FRAMING_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mac_valid = 1'b1;
  logic [31:0] delta = '0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid, mac_ready, busy, done, retry;
  fp32_result_serializer #(.MSB_FIRST(MSB), .ACK_TIMEOUT(TMO), .GAP_CLKS(GAP)) dut (
    .CLK_I(clk), .RST_I(rst), .MAC_VALID_I(mac_valid), .DELTA_I(delta), .TX_READY_I(tx_ready),
    .TX_DATA_O(tx_data), .TX_VALID_O(tx_valid), .MAC_READY_O(mac_ready), .BUSY_O(busy),
    .DONE_O(done), .RETRY_O(retry)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  int cyc_p = 0;
  int rise_cyc = 0;
  bit gap_pend = 0;
  bit ignore_next = 0;
  int acc_cnt = 0, nvalid = 0, ndone = 0, nretry = 0, nbusy = 0;
  logic prev_v = 1'b0;
  always @(posedge clk) cyc_p <= cyc_p + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic exp_push(input logic [31:0] w);
    logic [7:0] b;
    logic [7:0] cs;
    cs = '0;
`ifdef FP32_SER_FRAMING_EN
    q.push_back(8'hA5);
`endif
    for (int k = 0; k < 4; k++) begin
      b = MSB != 0 ? w[31 - 8 * k -: 8] : w[8 * k +: 8];
      cs ^= b;
      q.push_back(b);
    end
`ifdef FP32_SER_FRAMING_EN
    q.push_back(cs);
`endif
  endtask
  task automatic start_frame(input logic [31:0] w, input bit push);
    @(negedge clk);
    mac_valid = 1'b0;
    delta = w;
    @(negedge clk);
    mac_valid = 1'b1;
    if (push) exp_push(w);
  endtask
  task automatic wait_acc(input int n);
    for (int i = 0; i < 2000 && acc_cnt < n; i++) @(negedge clk);
    check("acc_reached", 32'(acc_cnt >= n), 1);
  endtask
  task automatic frame_check(input int d0, input int a0, input int r0, input int exp_retry);
    for (int i = 0; i < 3000 && ndone == d0; i++) @(negedge clk);
    check("done_seen", 32'(ndone > d0), 1);
    repeat (10) @(negedge clk);
    check("done_once", ndone - d0, 1);
    check("bytes_sent", acc_cnt - a0, NB);
    check("sb_drained", q.size(), 0);
    check("retries", nretry - r0, exp_retry);
  endtask
  // monitor: pulse widths and output consistency
  initial forever begin
    @(negedge clk);
    if (tx_valid) begin
      nvalid++;
      check("txv_pulse", prev_v, 0);
      check("busy_on_txv", busy, 1);
      check("mrdy_on_txv", mac_ready, 0);
    end
    prev_v = tx_valid;
    if (done) begin
      ndone++;
      gap_pend = 0;
    end
    if (retry) nretry++;
    if (!mac_ready) nbusy++;
  end
  // UART TX model: drops ready 3 cycles after a start pulse, frame lasts 20 cycles
  initial forever begin
    @(negedge clk);
    if (tx_valid) begin
      if (gap_pend) begin
        check("gap_cycles", cyc_p - rise_cyc, GAP + 3);
        gap_pend = 0;
      end
      check("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) check("tx_byte", tx_data, q[0]);
      if (ignore_next) begin
        ignore_next = 0;
      end else begin
        if (q.size() != 0) void'(q.pop_front());
        acc_cnt++;
        repeat (3) @(negedge clk);
        tx_ready = 1'b0;
        repeat (20) @(negedge clk);
        tx_ready = 1'b1;
        rise_cyc = cyc_p;
        gap_pend = busy;
      end
    end
  end
  initial begin
    int d0, a0, r0, v0, b0, lat;
    repeat (3) @(negedge clk);
    check("rst_txdata", tx_data, 0);
    check("rst_txvalid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_retry", retry, 0);
    check("rst_macready", mac_ready, 1);
    rst = 1'b0;
    v0 = nvalid;
    b0 = nbusy;
    repeat (100) @(negedge clk);
    check("hold_no_txv", nvalid - v0, 0);
    check("hold_ready", nbusy - b0, 0);
    d0 = ndone; a0 = acc_cnt; r0 = nretry;
    start_frame(32'hBEC0_0000, 1);
    lat = 0;
    for (int i = 0; i < 50 && !tx_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    check("first_latency", lat, 2);
    frame_check(d0, a0, r0, 0);
    d0 = ndone; a0 = acc_cnt; r0 = nretry;
    ignore_next = 1;
    start_frame(32'hBEC0_0000, 1);
    frame_check(d0, a0, r0, 1);
    d0 = ndone; a0 = acc_cnt; r0 = nretry;
    start_frame(32'hBEC0_0000, 1);
    wait_acc(a0 + 2);
    start_frame(32'h3E60_0000, 0);
    frame_check(d0, a0, r0, 0);
    d0 = ndone; a0 = acc_cnt; r0 = nretry;
    start_frame(32'h3E60_0000, 1);
    frame_check(d0, a0, r0, 0);
    d0 = ndone; a0 = acc_cnt;
    start_frame(32'hBEC0_0000, 1);
    wait_acc(a0 + 2);
    for (int i = 0; i < 50 && tx_ready; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_macready", mac_ready, 1);
    check("midrst_txvalid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    mac_valid = 1'b0;
    q.delete();
    for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
    check("midrst_no_done", ndone - d0, 0);
    d0 = ndone; a0 = acc_cnt; r0 = nretry;
    start_frame(32'hBEC0_0000, 1);
    frame_check(d0, a0, r0, 0);
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp32_result_serializer.md
Name: fp32_result_serializer

Overview:
- Consumer end of the MAC result handshake.
- Detects a new FP32 result from the MAC, captures the 32-bit word and splits it into bytes.
- Drives each byte into the UART transmitter using a start/ready handshake, then signals completion.
- Position in the datapath: rx → mac → **serializer** → tx.

Parameters:
- MSB_FIRST, 1, 1 = byte order [31:24],[23:16],[15:8],[7:0]; 0 = reverse order.
- ACK_TIMEOUT, 16, cycles to wait for TX_READY_I to fall after a start pulse before re-issuing the same byte.
- GAP_CLKS, 0, idle cycles inserted after each byte completes (0 = no gap).

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous active-high reset.
- MAC_VALID_I  in  1  MAC result-valid level. Stays high while the MAC idles; only its rising edge marks a new result.
- DELTA_I  in  32  FP32 result from the MAC.
- TX_READY_I  in  1  UART TX idle flag. High = idle; low while a frame is shifting.
- TX_DATA_O  out  8  byte to transmit.
- TX_VALID_O  out  1  one-cycle start pulse to the UART TX.
- MAC_READY_O  out  1  high when in IDLE and able to accept a result.
- BUSY_O  out  1  high in every state except IDLE.
- DONE_O  out  1  one-cycle pulse after the last byte completes.
- RETRY_O  out  1  one-cycle pulse on each timeout re-issue.

Behaviour:
- Reset is synchronous, active-high, sampled on posedge CLK_I.
  - State → IDLE.
  - TX_DATA_O=0, TX_VALID_O=0, BUSY_O=0, DONE_O=0, RETRY_O=0, MAC_READY_O=1.
  - Byte index, timeout counter, gap counter and capture register cleared.
  - Edge-detect history register is loaded with 1, so a MAC_VALID_I already high at reset does not trigger.
- Reset mid-frame: transfer aborts immediately and TX_VALID_O drops. The partial word is never resumed.
- Rising-edge detect: registered copy of MAC_VALID_I; edge = MAC_VALID_I & ~prev. Edges outside IDLE are ignored, with no queueing.
- IDLE: on edge, capture DELTA_I into shift_word (same cycle), clear the byte index, go to SEND.
- SEND:
  - If TX_READY_I=1: assert TX_VALID_O for exactly 1 cycle, with TX_DATA_O = selected byte. Clear the timeout counter and go to WAIT_ACK.
  - If TX_READY_I=0: stay in SEND.
  - TX_DATA_O holds its value until the next byte is issued.
- WAIT_ACK:
  - TX_READY_I=0 → WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT−1, pulse RETRY_O and return to SEND with the same byte.
- WAIT_DONE: on TX_READY_I=1 → GAP if GAP_CLKS>0, else NEXT.
- GAP: count GAP_CLKS cycles, then NEXT.
- NEXT:
  - If the byte index equals the last index: pulse DONE_O and go to IDLE.
  - Otherwise increment the index and go to SEND.
- Frame length and latency:
  - Frame length is 4 bytes.
  - Minimum latency from MAC_VALID_I edge to first TX_VALID_O is 2 cycles: capture, then SEND with TX_READY_I high.
- MAC_READY_O: combinational, equals (state==IDLE). BUSY_O = ~MAC_READY_O.
- Simultaneous events:
  - DONE_O pulse and a new edge in the same cycle: the edge is dropped, because the state is not yet IDLE.
  - TX_READY_I falling on the same cycle the timeout expires: the ack wins and the FSM goes to WAIT_DONE.
- No data-dependent arithmetic; the FP32 word is passed through bit-exact.

Optional Feature:
- FP32_SER_FRAMING_EN
- Defined:
  - Frame becomes 6 bytes: sync 0xA5, then the 4 data bytes in MSB_FIRST order, then a checksum byte.
  - Checksum = XOR of the 4 data bytes, accumulated as each byte is issued.
  - Last index = 5.
- Undefined: 4 raw bytes, no checksum logic synthesized.

Test Plan:
- Reset with MAC_VALID_I already high, then hold high for 100 cycles → no TX_VALID_O, MAC_READY_O=1 throughout.
- Basic frame: DELTA_I=0xBEC0_0000 (−0.5×0.75), MAC_VALID_I rises, TX model acks after 3 cycles and completes after 20 → bytes BE,C0,00,00, four TX_VALID_O pulses, one DONE_O. With MSB_FIRST=0 the order is 00,00,C0,BE.
- Timeout: TX model ignores the first start pulse, ACK_TIMEOUT=16 → RETRY_O after 16 cycles, byte 0xBE re-issued, frame completes normally.
- Busy drop: a second MAC_VALID_I edge with DELTA_I=0x3E60_0000 during byte 2 → ignored, frame still BE,C0,00,00. A later edge in IDLE sends 3E,60,00,00.
- Reset in WAIT_DONE of byte 1 → next cycle IDLE, TX_VALID_O=0. A fresh edge restarts at byte 0.
- FP32_SER_FRAMING_EN, DELTA_I=0x3E60_0000 → A5,3E,60,00,00,5E with 0x5E = 3E^60. GAP_CLKS=4 gives ≥4 idle cycles between each TX_READY_I rise and the next TX_VALID_O.
